trng_rosc_cntr_tx: RTL and testbench

- Sender side of the ring-oscillator measurement path. Runs entirely on the free-running oscillator clock (rnd_src_clk).
- Counts prescaled oscillator cycles. On request from the rng_clk domain, it publishes a stable count snapshot using a 4-phase-free toggle req/ack handshake.
- The rng_clk-domain receiver synchronizes snap_valid_tgl, reads snap_data while it is held stable, then returns snap_ack_tgl.
- Provides the oscillator-frequency data used by TRNG BIST and health checks.

---
 rtl/trng_rosc_pkg.sv | 17 +
 rtl/trng_rosc_cntr_tx_if.sv | 34 +++
 rtl/trng_bit_sync.sv | 29 ++
 rtl/trng_rosc_cntr_tx.sv | 172 +++++++++++++++++
 tb/tb_trng_rosc_cntr_tx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/trng_rosc_pkg.sv
// rtl/trng_rosc_pkg.sv - shared types and defaults for the ring-oscillator measurement path
//
// Contents:
//   tx_state_e         snapshot sender FSM encoding (ST_IDLE, ST_WAIT_ACK)
//   DEFAULT_CNT_W      default oscillator counter / snapshot width
//   DEFAULT_PRESC_LOG2 default prescaler shift, shared with the trng_sync BIST
package trng_rosc_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } tx_state_e;

  localparam int DEFAULT_CNT_W      = 22;
  localparam int DEFAULT_PRESC_LOG2 = 3;

endpackage

// File: rtl/trng_rosc_cntr_tx_if.sv
// rtl/trng_rosc_cntr_tx_if.sv - snapshot toggle handshake between oscillator and rng_clk domains
//
// Signals:
//   snap_req_tgl    toggle from the rng_clk domain, one transition per snapshot request
//   snap_ack_tgl    toggle from the receiver, set equal to snap_valid_tgl when done
//   snap_valid_tgl  toggle from the sender, one transition per published snapshot
//   snap_data       snapshot value, held stable while the handshake is open
// Modports:
//   master  oscillator-side sender (trng_rosc_cntr_tx)
//   slave   rng_clk-side receiver
interface trng_rosc_cntr_tx_if #(
  parameter int CNT_W = trng_rosc_pkg::DEFAULT_CNT_W
);

  logic             snap_req_tgl;
  logic             snap_ack_tgl;
  logic             snap_valid_tgl;
  logic [CNT_W-1:0] snap_data;

  modport master (
    input  snap_req_tgl,
    input  snap_ack_tgl,
    output snap_valid_tgl,
    output snap_data
  );

  modport slave (
    output snap_req_tgl,
    output snap_ack_tgl,
    input  snap_valid_tgl,
    input  snap_data
  );

endinterface

// File: rtl/trng_bit_sync.sv
// rtl/trng_bit_sync.sv - single-bit multi-flop synchronizer into rnd_src_clk
//
// Ports:
//   rnd_src_clk  destination clock
//   rst_n        asynchronous active-low reset, clears every stage to 0
//   d            asynchronous input
//   q            synchronized output, STAGES cycles of latency
module trng_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic rnd_src_clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge rnd_src_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/trng_rosc_cntr_tx.sv
// rtl/trng_rosc_cntr_tx.sv - oscillator cycle counter with toggle-handshake snapshot sender
//
// Ports:
//   rnd_src_clk  free-running ring-oscillator clock
//   rst_n        asynchronous active-low reset
//   cnt_en       counting enable level from rng_clk domain (synchronized here)
//   snap         trng_rosc_cntr_tx_if.master: req/ack toggles in, valid toggle and data out
//   busy         1 while a published snapshot awaits its ack
//   req_overrun  sticky, a snapshot request was dropped; cleared only by reset
//   cnt_wrapped  sticky, counter wrapped while enabled; cleared when counting is disabled
module trng_rosc_cntr_tx
  import trng_rosc_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int PRESC_LOG2  = DEFAULT_PRESC_LOG2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rnd_src_clk,
  input  logic                rst_n,
  input  logic                cnt_en,
  trng_rosc_cntr_tx_if.master snap,
  output logic                busy,
  output logic                req_overrun,
  output logic                cnt_wrapped
);

  logic en_s;
  logic req_s;
  logic ack_s;
  logic req_prev;
  logic req_edge;
  logic presc_tick;

  logic [CNT_W-1:0] cnt;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;

  trng_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_en (
    .rnd_src_clk (rnd_src_clk),
    .rst_n       (rst_n),
    .d           (cnt_en),
    .q           (en_s)
  );

  trng_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
    .rnd_src_clk (rnd_src_clk),
    .rst_n       (rst_n),
    .d           (snap.snap_req_tgl),
    .q           (req_s)
  );

  trng_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .rnd_src_clk (rnd_src_clk),
    .rst_n       (rst_n),
    .d           (snap.snap_ack_tgl),
    .q           (ack_s)
  );

  // Each transition of the synchronized request toggle is one request.
  always_ff @(posedge rnd_src_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev <= 1'b0;
    end else begin
      req_prev <= req_s;
    end
  end

  assign req_edge = req_s ^ req_prev;

  // Prescaler: with PRESC_LOG2 = 0 there is no divider and the counter
  // advances on every enabled cycle.
  generate
    if (PRESC_LOG2 == 0) begin : g_no_presc
      assign presc_tick = 1'b1;
    end else begin : g_presc
      logic [PRESC_LOG2-1:0] presc;

      always_ff @(posedge rnd_src_clk or negedge rst_n) begin
        if (!rst_n) begin
          presc <= '0;
        end else if (!en_s) begin
          presc <= '0;
        end else begin
          presc <= presc + PRESC_LOG2'(1);
        end
      end

      assign presc_tick = (presc == '1);
    end
  endgenerate

  always_ff @(posedge rnd_src_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      cnt_wrapped <= 1'b0;
    end else if (!en_s) begin
      cnt         <= '0;
      cnt_wrapped <= 1'b0;
    end else if (presc_tick) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == '1) begin
        cnt_wrapped <= 1'b1;
      end
    end
  end

  always_ff @(posedge rnd_src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // A request arriving while a snapshot is open is parked in pending; only a
  // second one while pending is already set is dropped. An ack match and a
  // new request in the same cycle still close the handshake, and the parked
  // request is served from IDLE on the following cycle.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (req_edge || pending_q) begin
          data_d    = cnt;
          valid_d   = ~valid_q;
          pending_d = 1'b0;
          state_d   = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        if (req_edge) begin
          if (pending_q) begin
            overrun_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end
        if (ack_s == valid_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign snap.snap_valid_tgl = valid_q;
  assign snap.snap_data      = data_q;
  assign busy                = (state_q == ST_WAIT_ACK);
  assign req_overrun         = overrun_q;

endmodule

// File: tb/tb_trng_rosc_cntr_tx.sv
// tb/tb_trng_rosc_cntr_tx.sv - directed self-checking bench for trng_rosc_cntr_tx
module tb_trng_rosc_cntr_tx;

  logic rnd_src_clk;
  logic rst_n;

  logic cnt_en_a, busy_a, overrun_a, wrapped_a;
  logic cnt_en_b, busy_b, overrun_b, wrapped_b;

  int n_chk;
  int n_pass;

  trng_rosc_cntr_tx_if #(.CNT_W(22)) snap_a ();
  trng_rosc_cntr_tx_if #(.CNT_W(4))  snap_b ();

  trng_rosc_cntr_tx #(
    .CNT_W       (22),
    .PRESC_LOG2  (3),
    .SYNC_STAGES (2)
  ) u_dut_a (
    .rnd_src_clk (rnd_src_clk),
    .rst_n       (rst_n),
    .cnt_en      (cnt_en_a),
    .snap        (snap_a),
    .busy        (busy_a),
    .req_overrun (overrun_a),
    .cnt_wrapped (wrapped_a)
  );

  trng_rosc_cntr_tx #(
    .CNT_W       (4),
    .PRESC_LOG2  (0),
    .SYNC_STAGES (2)
  ) u_dut_b (
    .rnd_src_clk (rnd_src_clk),
    .rst_n       (rst_n),
    .cnt_en      (cnt_en_b),
    .snap        (snap_b),
    .busy        (busy_b),
    .req_overrun (overrun_b),
    .cnt_wrapped (wrapped_b)
  );

  initial rnd_src_clk = 1'b0;
  always #5 rnd_src_clk = ~rnd_src_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge rnd_src_clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    cnt_en_a = 1'b0;
    cnt_en_b = 1'b0;
    snap_a.snap_req_tgl = 1'b0;
    snap_a.snap_ack_tgl = 1'b0;
    snap_b.snap_req_tgl = 1'b0;
    snap_b.snap_ack_tgl = 1'b0;

    tick(3);
    check("rst_valid",   32'(snap_a.snap_valid_tgl), 32'd0);
    check("rst_data",    32'(snap_a.snap_data),      32'd0);
    check("rst_busy",    32'(busy_a),                32'd0);
    check("rst_overrun", 32'(overrun_a),             32'd0);
    check("rst_wrapped", 32'(wrapped_a),             32'd0);
    rst_n = 1'b1;
    tick(2);

    // Count/capture: 100 enabled cycles, /8 prescale -> 12.
    cnt_en_a = 1'b1;
    tick(100);
    snap_a.snap_req_tgl = 1'b1;
    tick(2);
    check("cap_not_early", 32'(snap_a.snap_valid_tgl), 32'd0);
    tick(1);
    check("cap_valid", 32'(snap_a.snap_valid_tgl), 32'd1);
    check("cap_data",  32'(snap_a.snap_data),      32'd12);
    check("cap_busy",  32'(busy_a),                32'd1);

    // Handshake hold: data frozen while counter runs.
    tick(50);
    check("hold_data", 32'(snap_a.snap_data), 32'd12);
    check("hold_busy", 32'(busy_a),           32'd1);
    snap_a.snap_ack_tgl = 1'b1;
    tick(2);
    check("ack_busy_still", 32'(busy_a), 32'd1);
    tick(1);
    check("ack_busy_fall", 32'(busy_a),           32'd0);
    check("ack_data_kept", 32'(snap_a.snap_data), 32'd12);

    // Pending/overrun.
    snap_a.snap_req_tgl = 1'b0;
    tick(3);
    check("pend_cap_valid", 32'(snap_a.snap_valid_tgl), 32'd0);
    check("pend_cap_busy",  32'(busy_a),                32'd1);
    tick(3);
    snap_a.snap_req_tgl = 1'b1;
    tick(4);
    check("pend_no_overrun", 32'(overrun_a), 32'd0);
    snap_a.snap_req_tgl = 1'b0;
    tick(4);
    check("overrun_set",   32'(overrun_a),             32'd1);
    check("overrun_valid", 32'(snap_a.snap_valid_tgl), 32'd0);
    snap_a.snap_ack_tgl = 1'b0;
    tick(3);
    check("pend_idle_busy",  32'(busy_a),                32'd0);
    check("pend_idle_valid", 32'(snap_a.snap_valid_tgl), 32'd0);
    tick(1);
    check("pend_serve_valid", 32'(snap_a.snap_valid_tgl), 32'd1);
    check("pend_serve_busy",  32'(busy_a),                32'd1);
    tick(10);
    check("pend_single", 32'(snap_a.snap_valid_tgl), 32'd1);
    snap_a.snap_ack_tgl = 1'b1;
    tick(3);
    check("pend_done_busy", 32'(busy_a),    32'd0);
    check("overrun_sticky", 32'(overrun_a), 32'd1);

    // Enable clear: disabled counter snapshots as 0.
    cnt_en_a = 1'b0;
    tick(4);
    snap_a.snap_req_tgl = 1'b1;
    tick(3);
    check("dis_valid", 32'(snap_a.snap_valid_tgl), 32'd0);
    check("dis_data",  32'(snap_a.snap_data),      32'd0);
    check("dis_busy",  32'(busy_a),                32'd1);
    snap_a.snap_ack_tgl = 1'b0;
    tick(3);
    check("dis_done_busy", 32'(busy_a), 32'd0);

    // Wrap: 4-bit counter, no prescale; capture reads (20-2) mod 16 = 2.
    cnt_en_b = 1'b1;
    tick(16);
    check("wrap_not_yet", 32'(wrapped_b), 32'd0);
    tick(2);
    check("wrap_set", 32'(wrapped_b), 32'd1);
    snap_b.snap_req_tgl = 1'b1;
    tick(3);
    check("wrap_valid",   32'(snap_b.snap_valid_tgl), 32'd1);
    check("wrap_data",    32'(snap_b.snap_data),      32'd2);
    check("wrap_sticky",  32'(wrapped_b),             32'd1);
    cnt_en_b = 1'b0;
    snap_b.snap_ack_tgl = 1'b1;
    tick(3);
    check("wrap_clr",      32'(wrapped_b), 32'd0);
    check("wrap_ack_busy", 32'(busy_b),    32'd0);
    snap_b.snap_req_tgl = 1'b0;
    tick(3);
    check("wrap_cnt_zero",  32'(snap_b.snap_data),      32'd0);
    check("wrap_cnt_valid", 32'(snap_b.snap_valid_tgl), 32'd0);
    check("wrap_overrun",   32'(overrun_b),             32'd0);

    // Reset mid-handshake.
    cnt_en_a = 1'b1;
    snap_a.snap_req_tgl = 1'b0;
    tick(3);
    check("mid_busy",  32'(busy_a),                32'd1);
    check("mid_valid", 32'(snap_a.snap_valid_tgl), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid",   32'(snap_a.snap_valid_tgl), 32'd0);
    check("arst_busy",    32'(busy_a),                32'd0);
    check("arst_data",    32'(snap_a.snap_data),      32'd0);
    check("arst_overrun", 32'(overrun_a),             32'd0);
    snap_a.snap_req_tgl = 1'b0;
    snap_a.snap_ack_tgl = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    snap_a.snap_req_tgl = 1'b1;
    tick(3);
    check("post_valid",   32'(snap_a.snap_valid_tgl), 32'd1);
    check("post_data",    32'(snap_a.snap_data),      32'd2);
    check("post_busy",    32'(busy_a),                32'd1);
    check("post_overrun", 32'(overrun_a),             32'd0);
    snap_a.snap_ack_tgl = 1'b1;
    tick(3);
    check("post_done_busy", 32'(busy_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
